// File: rtl/hack_rom_loader_if.sv
// Byte-stream and ROM-write bundle for hack_rom_loader.
//   rx_valid  : input byte valid (source -> loader)
//   rx_data   : input byte (source -> loader)
//   rx_ready  : loader can take a byte (loader -> source)
//   rom_we    : ROM write strobe, one cycle per word (loader -> ROM)
//   rom_addr  : ROM write address (loader -> ROM)
//   rom_wdata : ROM write data (loader -> ROM)
// The loader uses the slave modport; the byte source / ROM side uses master.
interface hack_rom_loader_if #(
   parameter int ROM_ADDR_W = 15
) ();
   logic                  rx_valid;
   logic [7:0]            rx_data;
   logic                  rx_ready;
   logic                  rom_we;
   logic [ROM_ADDR_W-1:0] rom_addr;
   logic [15:0]           rom_wdata;

   modport slave (
      input  rx_valid,
      input  rx_data,
      output rx_ready,
      output rom_we,
      output rom_addr,
      output rom_wdata
   );

   modport master (
      output rx_valid,
      output rx_data,
      input  rx_ready,
      input  rom_we,
      input  rom_addr,
      input  rom_wdata
   );
endinterface

// File: rtl/hack_rom_loader.sv
// Framed program loader for the Hack instruction ROM.
// Frame: LEN_HI, LEN_LO, N x (WORD_HI, WORD_LO), CKSUM, where CKSUM is the
// XOR of every preceding frame byte. The CPU is held in reset (cpu_xrst=0)
// until a frame with a matching checksum has been fully written.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous reset, active-high
//   bus      : byte stream in / ROM write port out (hack_rom_loader_if.slave)
//   cpu_xrst : active-low reset to the CPU; 1 only after a good load
//   busy     : a frame is in progress
//   done     : last frame loaded OK
//   err      : last frame failed (length, checksum or timeout)
module hack_rom_loader #(
   parameter int ROM_ADDR_W     = 15,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                    clk,
   input  logic                    rst,
   hack_rom_loader_if.slave        bus,
   output logic                    cpu_xrst,
   output logic                    busy,
   output logic                    done,
   output logic                    err
);

   // Index is one bit wider than the address so a full 2**ROM_ADDR_W
   // word frame can be counted without the address wrapping.
   localparam int IW = ROM_ADDR_W + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_DATA_HI, S_DATA_LO, S_CKSUM, S_DONE, S_ERR
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            len_hi_q, len_hi_d;
   logic [15:0]           len_q, len_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [7:0]            hi_q, hi_d;
   logic [7:0]            cks_q, cks_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  rom_we_q, rom_we_d;
   logic [ROM_ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic [15:0]           rom_wdata_q, rom_wdata_d;
   logic                  cpu_xrst_q, cpu_xrst_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic                  acc;
   logic                  in_frame;
   logic [15:0]           len_w;

   assign bus.rx_ready = 1'b1;
   assign acc          = bus.rx_valid & bus.rx_ready;
   assign len_w        = {len_hi_q, bus.rx_data};
   assign in_frame     = (state_q == S_LEN_LO) || (state_q == S_DATA_HI) ||
                         (state_q == S_DATA_LO) || (state_q == S_CKSUM);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len_hi_q    <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         hi_q        <= '0;
         cks_q       <= '0;
         tmo_q       <= '0;
         rom_we_q    <= 1'b0;
         rom_addr_q  <= '0;
         rom_wdata_q <= '0;
         cpu_xrst_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_hi_q    <= len_hi_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         hi_q        <= hi_d;
         cks_q       <= cks_d;
         tmo_q       <= tmo_d;
         rom_we_q    <= rom_we_d;
         rom_addr_q  <= rom_addr_d;
         rom_wdata_q <= rom_wdata_d;
         cpu_xrst_q  <= cpu_xrst_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      len_hi_d    = len_hi_q;
      len_d       = len_q;
      idx_d       = idx_q;
      hi_d        = hi_q;
      cks_d       = cks_q;
      tmo_d       = tmo_q;
      rom_we_d    = 1'b0;
      rom_addr_d  = rom_addr_q;
      rom_wdata_d = rom_wdata_q;
      cpu_xrst_d  = cpu_xrst_q;
      busy_d      = busy_q;
      done_d      = done_q;
      err_d       = err_q;

      // Inter-byte timeout; only an accepted byte resets it.
      if (in_frame) begin
         if (acc) begin
            tmo_d = '0;
         end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            tmo_d      = '0;
            state_d    = S_ERR;
            err_d      = 1'b1;
            busy_d     = 1'b0;
            cpu_xrst_d = 1'b0;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            // Any byte here is LEN_HI of a fresh frame.
            if (acc) begin
               len_hi_d   = bus.rx_data;
               cks_d      = bus.rx_data;
               tmo_d      = '0;
               done_d     = 1'b0;
               err_d      = 1'b0;
               busy_d     = 1'b1;
               cpu_xrst_d = 1'b0;
               state_d    = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (acc) begin
               len_d = len_w;
               cks_d = cks_q ^ bus.rx_data;
               if (32'(len_w) > (32'd1 << ROM_ADDR_W)) begin
                  state_d    = S_ERR;
                  err_d      = 1'b1;
                  busy_d     = 1'b0;
                  cpu_xrst_d = 1'b0;
               end else if (len_w == 16'd0) begin
                  state_d = S_CKSUM;
               end else begin
                  idx_d      = '0;
                  rom_addr_d = '0;
                  state_d    = S_DATA_HI;
               end
            end
         end
         S_DATA_HI: begin
            if (acc) begin
               hi_d    = bus.rx_data;
               cks_d   = cks_q ^ bus.rx_data;
               state_d = S_DATA_LO;
            end
         end
         S_DATA_LO: begin
            if (acc) begin
               cks_d       = cks_q ^ bus.rx_data;
               rom_we_d    = 1'b1;
               rom_wdata_d = {hi_q, bus.rx_data};
               rom_addr_d  = idx_q[ROM_ADDR_W-1:0];
               idx_d       = idx_q + 1'b1;
               if ((32'(idx_q) + 32'd1) == 32'(len_q)) begin
                  state_d = S_CKSUM;
               end else begin
                  state_d = S_DATA_HI;
               end
            end
         end
         S_CKSUM: begin
            if (acc) begin
               busy_d = 1'b0;
               if (bus.rx_data == cks_q) begin
                  state_d    = S_DONE;
                  done_d     = 1'b1;
                  cpu_xrst_d = 1'b1;
               end else begin
                  state_d    = S_ERR;
                  err_d      = 1'b1;
                  cpu_xrst_d = 1'b0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign bus.rom_we    = rom_we_q;
   assign bus.rom_addr  = rom_addr_q;
   assign bus.rom_wdata = rom_wdata_q;
   assign cpu_xrst      = cpu_xrst_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign err           = err_q;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Testbench for hack_rom_loader: ROM writes checked against a queue of
// expected {addr, data} pairs; status outputs checked after each frame.
module tb_hack_rom_loader;

   localparam int AW = 15;
   localparam int TO = 16;

   logic clk;
   logic rst;
   logic cpu_xrst;
   logic busy;
   logic done;
   logic err;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] exp_q[$];

   hack_rom_loader_if #(.ROM_ADDR_W(AW)) bus ();

   hack_rom_loader #(
      .ROM_ADDR_W    (AW),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .cpu_xrst(cpu_xrst),
      .busy    (busy),
      .done    (done),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [14:0] addr, input logic [15:0] data);
      exp_q.push_back({1'b0, addr, data});
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.rx_valid = 1'b1;
      bus.rx_data  = b;
      @(posedge clk);
      #1;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
   endtask

   task automatic send_frame1(input logic [7:0] cks);
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h3C);
      send_byte(8'h00);
      send_byte(8'hEC);
      send_byte(8'h10);
      send_byte(cks);
   endtask

   task automatic check_status(input string tag, input logic b, input logic d,
                               input logic e, input logic x);
      check_eq({tag, "_busy"}, 32'(busy), 32'(b));
      check_eq({tag, "_done"}, 32'(done), 32'(d));
      check_eq({tag, "_err"}, 32'(err), 32'(e));
      check_eq({tag, "_xrst"}, 32'(cpu_xrst), 32'(x));
   endtask

   // Write monitor: every rom_we pulse must match the head of the queue.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (!rst && bus.rom_we === 1'b1) begin
            if (exp_q.size() == 0) begin
               check_eq("we_spurious", 32'(bus.rom_we), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check_eq("wr_addr", 32'(bus.rom_addr), {17'd0, e[30:16]});
               check_eq("wr_data", 32'(bus.rom_wdata), {16'd0, e[15:0]});
            end
         end
      end
   end

   // Global guard against a hung run.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      rst          = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_status("reset", 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("reset_we", 32'(bus.rom_we), 32'd0);
      check_eq("reset_addr", 32'(bus.rom_addr), 32'd0);
      check_eq("reset_wdata", 32'(bus.rom_wdata), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_eq("ready", 32'(bus.rx_ready), 32'd1);

      // Test 1: good two-word frame
      push_exp(15'd0, 16'h3C00);
      push_exp(15'd1, 16'hEC10);
      send_byte(8'h00);
      check_status("t1_start", 1'b1, 1'b0, 1'b0, 1'b0);
      send_byte(8'h02);
      send_byte(8'h3C);
      send_byte(8'h00);
      send_byte(8'hEC);
      send_byte(8'h10);
      send_byte(8'hC2);
      @(negedge clk);
      check_status("t1_end", 1'b0, 1'b1, 1'b0, 1'b1);
      check_eq("t1_pending", 32'(exp_q.size()), 32'd0);
      check_eq("t1_addr_hold", 32'(bus.rom_addr), 32'd1);

      // Test 2: same frame, bad checksum
      push_exp(15'd0, 16'h3C00);
      push_exp(15'd1, 16'hEC10);
      send_byte(8'h00);
      check_status("t2_start", 1'b1, 1'b0, 1'b0, 1'b0);
      send_byte(8'h02);
      send_byte(8'h3C);
      send_byte(8'h00);
      send_byte(8'hEC);
      send_byte(8'h10);
      send_byte(8'hC3);
      @(negedge clk);
      check_status("t2_end", 1'b0, 1'b0, 1'b1, 1'b0);
      check_eq("t2_pending", 32'(exp_q.size()), 32'd0);

      // Test 3: empty program
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      @(negedge clk);
      check_status("t3_end", 1'b0, 1'b1, 1'b0, 1'b1);

      // Test 4: oversize length, then recovery
      send_byte(8'h80);
      send_byte(8'h01);
      @(negedge clk);
      check_status("t4_len", 1'b0, 1'b0, 1'b1, 1'b0);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      @(negedge clk);
      check_status("t4_recover", 1'b0, 1'b1, 1'b0, 1'b1);

      // Test 5: stall inside a frame
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h3C);
      repeat (TO - 1) @(posedge clk);
      #1;
      check_status("t5_before", 1'b1, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      check_status("t5_timeout", 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (5) @(posedge clk);
      #1;
      check_eq("t5_err_held", 32'(err), 32'd1);
      push_exp(15'd0, 16'h3C00);
      push_exp(15'd1, 16'hEC10);
      send_frame1(8'hC2);
      @(negedge clk);
      check_status("t5_restart", 1'b0, 1'b1, 1'b0, 1'b1);
      check_eq("t5_pending", 32'(exp_q.size()), 32'd0);

      // Test 6: reset while in DATA_LO
      push_exp(15'd0, 16'h3C00);
      send_byte(8'h00);
      send_byte(8'h02);
      send_byte(8'h3C);
      send_byte(8'h00);
      send_byte(8'hEC);
      rst = 1'b1;
      #2;
      check_status("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0);
      check_eq("t6_we", 32'(bus.rom_we), 32'd0);
      check_eq("t6_addr", 32'(bus.rom_addr), 32'd0);
      check_eq("t6_wdata", 32'(bus.rom_wdata), 32'd0);
      check_eq("t6_pending", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      push_exp(15'd0, 16'h3C00);
      push_exp(15'd1, 16'hEC10);
      send_frame1(8'hC2);
      @(negedge clk);
      check_status("t6_after", 1'b0, 1'b1, 1'b0, 1'b1);
      check_eq("t6_pending_end", 32'(exp_q.size()), 32'd0);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
